// File: rtl/s444_bist_ctrl.sv
// BIST sequencer for the s444 benchmark: flushes the DUT, drives LFSR stimulus,
// compacts the six responses into a 16-bit MISR and reports the signature against GOLDEN.
module s444_bist_ctrl #(
    parameter int unsigned CYCLES       = 1024,
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter logic [15:0] GOLDEN       = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [5:0]  dut_resp_i,
    output logic        dut_g0_o,
    output logic        dut_g1_o,
    output logic        dut_g2_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] signature_o,
    output logic        pass_o
);

    typedef enum logic [2:0] {StIdle, StFlush, StRun, StDrain, StDone} state_e;

    localparam logic [15:0] RunLast   = 16'(CYCLES - 1);
    localparam logic [15:0] FlushLast = 16'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] misr_q, misr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] sig_q, sig_d;
    logic        pass_q, pass_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] r);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {10'b0, r};
    endfunction

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        pass_d  = pass_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFlush;
                    lfsr_d  = SEED;
                    misr_d  = 16'h0000;
                    cnt_d   = 16'h0000;
                end
            end
            StFlush: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == FlushLast) begin
                    state_d = StRun;
                    cnt_d   = 16'h0000;
                end
            end
            StRun: begin
                lfsr_d = lfsr_step(lfsr_q);
                misr_d = misr_step(misr_q, dut_resp_i);
                cnt_d  = cnt_q + 16'd1;
                if (cnt_q == RunLast) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Last MISR update absorbs the response to the final RUN vector.
                misr_d  = misr_step(misr_q, dut_resp_i);
                sig_d   = misr_d;
                pass_d  = (misr_d == GOLDEN);
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort_i) begin
            state_d = StIdle;
            sig_d   = sig_q;
            pass_d  = pass_q;
        end

        busy_d = (state_d == StFlush) || (state_d == StRun) || (state_d == StDrain);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            misr_q  <= 16'h0000;
            cnt_q   <= 16'h0000;
            sig_q   <= 16'h0000;
            pass_q  <= (GOLDEN == 16'h0000);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Stimulus is decoded from registered state only, so no input reaches it combinationally.
    always_comb begin
        dut_g0_o = 1'b0;
        dut_g1_o = 1'b0;
        dut_g2_o = 1'b0;
        case (state_q)
            StFlush: dut_g0_o = 1'b1;
            StRun: begin
                dut_g0_o = &lfsr_q[2:0];
                dut_g1_o = lfsr_q[3];
                dut_g2_o = lfsr_q[4];
            end
            default: ;
        endcase
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign signature_o = sig_q;
    assign pass_o      = pass_q;

endmodule

// File: doc/s444_bist_ctrl.md
# s444_bist_ctrl

Built-in self-test sequencer for the s444 benchmark in the iscas89 example application. It owns the DUT's three primary inputs (G0, G1, G2). It flushes the DUT state by holding G0 high, then drives pseudo-random stimulus from an LFSR. The six DUT outputs are compacted into a 16-bit MISR signature, which is compared against a golden value and reported with a start/done handshake to the host fabric logic.

## Interface
- CYCLES, 1024: number of RUN cycles; legal range 1..65535
- FLUSH_CYCLES, 4: number of cycles G0 is held high before RUN; legal range 1..255
- SEED, 16'hACE1: LFSR seed loaded on each start; must be nonzero
- GOLDEN, 16'h0000: expected signature that `pass` compares against

- clk  in  1  rising-edge clock, shared with the DUT
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a test; sampled only in IDLE
- abort  in  1  return to IDLE from any state; no done pulse
- dut_resp  in  6  DUT outputs, bit order {G168,G167,G119,G118,G108,G107}
- dut_g0, dut_g1, dut_g2  out  1 each  DUT primary inputs
- busy  out  1  high in FLUSH, RUN and DRAIN
- done  out  1  one-cycle pulse on completion
- signature  out  16  final MISR value; held until the next start
- pass  out  1  signature == GOLDEN; valid when done fires, held with signature

## Operation
- States: IDLE, FLUSH, RUN, DRAIN, DONE. Encoding is free.
- IDLE: start=1 moves to FLUSH. Loads lfsr<=SEED, misr<=0, cnt<=0.
- FLUSH: dut_g0=1, dut_g1=0, dut_g2=0. cnt increments. When cnt==FLUSH_CYCLES-1: go to RUN and set cnt<=0. MISR is not updated.
- RUN: dut_g0 = &lfsr[2:0], dut_g1 = lfsr[3], dut_g2 = lfsr[4].
  - At every edge: lfsr advances, misr updates, cnt increments.
  - When cnt==CYCLES-1: go to DRAIN.
- DRAIN: one cycle with stimulus forced to 0. It captures the response to the last RUN vector; misr updates once more. Then go to DONE.
- DONE: one cycle. done=1; signature<=misr and pass updated at the DRAIN→DONE edge. Then go to IDLE.
- LFSR: Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - fb = l[15]^l[13]^l[12]^l[10]
  - l <= {l[14:0], fb}
- MISR: m <= {m[14:0], m[15]^m[13]^m[12]^m[10]} ^ {10'b0, dut_resp}.
- Total MISR updates per test: exactly CYCLES+1.
- abort has priority over every transition, including start in the same cycle.
  - Next state is IDLE; stimulus returns to 0.
  - signature and pass keep their previous values; no done pulse.
- start while busy is ignored.
- Counter is 16 bits; no wrap-around is reachable for legal parameters.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0
  - dut_g0=0, dut_g1=0, dut_g2=0
  - signature=0, pass=(GOLDEN==0)
  - lfsr=SEED, misr=0, cnt=0
- Reset mid-operation: immediate return to the reset values. The DUT is not flushed until the next start.
- All outputs are registered except the dut_g* stimulus, which is decoded from state and lfsr (no combinational path from inputs).
- Cycle numbering: start sampled at edge 0.
  - FLUSH: cycles 1..F
  - RUN: cycles F+1..F+N
  - DRAIN: cycle F+N+1
  - done high during cycle F+N+2
  - IDLE again from cycle F+N+3; a new start is accepted there
- busy rises at cycle 1 and falls at the start of cycle F+N+2, when done rises.

## Test plan
- Reset then idle:
  - Stimulus: rst_n=0 for 3 cycles, then 10 idle cycles.
  - Required: busy=0, done=0, dut_g*=0, signature=0 throughout.
- Nominal run, F=4, N=8:
  - Stimulus: pulse start at edge 0.
  - Required: dut_g0=1 in cycles 1..4; first RUN vector in cycle 5 is g0=0, g1=0, g2=0 (SEED bits[4:0]=00001); done in cycle 14 only.
  - Required: signature equals the bench model run over the DUT outputs for 9 updates.
- Golden match:
  - Stimulus: set GOLDEN to the signature from the previous run and rerun.
  - Required: pass=1. With GOLDEN^16'h0001: pass=0.
- Abort:
  - Stimulus: abort in RUN cycle 7.
  - Required: next cycle busy=0, no done, signature unchanged. A fresh start afterwards reproduces the nominal signature.
- Start collisions:
  - Stimulus: start held high for the whole run; separately, start and abort together in IDLE.
  - Required: held start gives exactly one done pulse per completed test, with restart in cycle F+N+3. Start+abort stays in IDLE.
- Async reset mid-FLUSH:
  - Stimulus: assert rst_n=0 asynchronously during cycle 2.
  - Required: all outputs go to their reset values before the next edge.
